exc_handler: RTL and testbench
==============================

// Module: exc_handler
// PURPOSE
//   Exception/interrupt responder for the single-cycle LEGv8 core. Consumes the
//   main decoder's NotAnInstr/ERet flags plus an external interrupt line, saves
//   the return PC (ELR) and a syndrome (ESR), and redirects fetch to the handler
//   vector or back to ELR. Sits beside the PC mux; MRS reads its registers.
// PARAMETERS
//   VECTOR  64'h0000_0000_0000_00D8  handler entry address
//   ESR_W   4                        syndrome register width
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-high
//   NotAnInstr   in   1      decoder: current opcode invalid
//   ERet         in   1      decoder: current instruction is ERET
//   ExtIRQ       in   1      external interrupt request, level
//   PC           in   64     address of current instruction
//   NextPC       in   64     PC the core would fetch next (post-branch)
//   SysRegSel    in   2      MRS source select
//   ExcRedirect  out  1      combinational: PC mux must take RedirectPC
//   RedirectPC   out  64     combinational: VECTOR or ELR
//   SysRegOut    out  64     combinational MRS read data
//   ExtIAck      out  1      registered one-cycle interrupt acknowledge
//   EProc        out  1      1 while in HANDLER state
//   Halt         out  1      sticky double-fault indicator
// BEHAVIOUR
//   Reset (async): state=NORMAL, ELR=0, ESR=0, irq_pend=0, ExtIAck=0, Halt=0.
//   irq_pend: set on any edge with ExtIRQ=1 and irq_pend=0; cleared when taken.
//   States: NORMAL, HANDLER, HALTED (EProc = state==HANDLER).
//   NORMAL, per cycle, priority high->low (combinational decision, regs at edge):
//     NotAnInstr: ExcRedirect=1, RedirectPC=VECTOR; ELR<=PC, ESR<=4'b0010;
//       ->HANDLER. irq_pend kept.
//     ERet: illegal outside handler: as above but ESR<=4'b0100.
//     irq_pend: current instr commits; ExcRedirect=1, RedirectPC=VECTOR;
//       ELR<=NextPC, ESR<=4'b0001, irq_pend<=0, ExtIAck<=1 next cycle; ->HANDLER.
//     else ExcRedirect=0.
//   HANDLER: interrupts masked (irq_pend held, not taken).
//     ERet: ExcRedirect=1, RedirectPC=ELR; ->NORMAL; ELR/ESR unchanged.
//     NotAnInstr: double fault: ESR<=4'b1000, Halt<=1, ->HALTED;
//       ExcRedirect=1, RedirectPC=PC (core spins on same address).
//     NotAnInstr and ERet never both 1 (decoder guarantee); NotAnInstr wins.
//   HALTED: ExcRedirect=1, RedirectPC=PC every cycle; only reset exits.
//   ExtIAck: exactly one cycle high, the cycle after an IRQ is taken; else 0.
//   Pending IRQ at ERet: ERet cycle returns to NORMAL; IRQ taken on the next
//     cycle with ELR=NextPC of that instruction (at least one instr executes).
//   SysRegOut: 00->ELR, 01->{60'b0,ESR}, 10->{62'b0,state}, 11->64'b0.
//   ESR zero-extended; no arithmetic on PC values (pass-through only).
//   Reset mid-handler: back to NORMAL, ELR/ESR cleared, pending IRQ dropped.
// TESTING
//   NotAnInstr=1, PC=0x40 in NORMAL -> ExcRedirect=1, RedirectPC=0xD8 same
//     cycle; next: ELR=0x40, ESR=2, EProc=1.
//   ExtIRQ pulse 1 cycle, NextPC=0x48 -> taken next cycle: ELR=0x48, ESR=1;
//     ExtIAck high exactly one cycle after take.
//   ExtIRQ during HANDLER -> no redirect until ERet; ERet redirects to ELR,
//     next cycle IRQ taken (ESR=1), ExtIAck pulse.
//   NotAnInstr and irq_pend same cycle, PC=0x10 -> ESR=2, ELR=0x10, pending
//     retained and serviced after ERet.
//   NotAnInstr in HANDLER, PC=0xE0 -> Halt=1, ESR=8, RedirectPC=0xE0 each cycle;
//     assert reset async -> Halt=0, EProc=0, ELR=0, ESR=0 immediately.
//   SysRegSel sweep 0..3 with ELR=0x48, ESR=1, HANDLER -> 0x48, 1, 1, 0.

Source files
------------

// File: rtl/exc_handler_if.sv
// Signal bundle between the core (PC mux, decoder, MRS path) and the
// exception/interrupt responder.
interface exc_handler_if;

  // Core-side status and request inputs
  logic        NotAnInstr;
  logic        ERet;
  logic        ExtIRQ;
  logic [63:0] PC;
  logic [63:0] NextPC;
  logic [1:0]  SysRegSel;

  // Responder outputs
  logic        ExcRedirect;
  logic [63:0] RedirectPC;
  logic [63:0] SysRegOut;
  logic        ExtIAck;
  logic        EProc;
  logic        Halt;

  // Core side: drives decode flags and PCs, consumes redirect and MRS data
  modport master (
    output NotAnInstr, ERet, ExtIRQ, PC, NextPC, SysRegSel,
    input  ExcRedirect, RedirectPC, SysRegOut, ExtIAck, EProc, Halt
  );

  // Responder side
  modport slave (
    input  NotAnInstr, ERet, ExtIRQ, PC, NextPC, SysRegSel,
    output ExcRedirect, RedirectPC, SysRegOut, ExtIAck, EProc, Halt
  );

endinterface

// File: rtl/exc_handler.sv
// Exception/interrupt responder for the single-cycle LEGv8 core.
// Captures the return PC (ELR) and a syndrome (ESR), steers fetch to the
// handler vector or back to ELR, and latches a sticky halt on double fault.
// ExcRedirect, RedirectPC and SysRegOut are combinational so the PC mux and
// MRS path see them in the same cycle; everything else is registered.
module exc_handler #(
  parameter logic [63:0] VECTOR = 64'h0000_0000_0000_00D8,
  parameter int unsigned ESR_W  = 4
) (
  input  logic          clk,
  input  logic          reset,
  exc_handler_if.slave  bus
);

  localparam int unsigned PC_W = 64;

  // Syndrome encodings (one-hot cause)
  localparam logic [ESR_W-1:0] ESR_IRQ     = ESR_W'(1);
  localparam logic [ESR_W-1:0] ESR_UNDEF   = ESR_W'(2);
  localparam logic [ESR_W-1:0] ESR_ILLERET = ESR_W'(4);
  localparam logic [ESR_W-1:0] ESR_DBLFLT  = ESR_W'(8);

  // Encoding is architecturally visible through MRS select 2'b10
  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_HANDLER = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   elr_q, elr_d;
  logic [ESR_W-1:0]  esr_q, esr_d;
  logic              irq_pend_q, irq_pend_d;
  logic              ext_iack_q, ext_iack_d;
  logic              halt_q, halt_d;

  // Per-cycle event decode
  logic take_undef;
  logic take_ill_eret;
  logic take_irq;
  logic do_return;
  logic dbl_fault;

  logic            redirect_c;
  logic [PC_W-1:0] redirect_pc_c;
  logic [PC_W-1:0] sysreg_c;

  // Classify this cycle's event by state and priority (NotAnInstr > ERet > IRQ)
  always_comb begin
    take_undef    = 1'b0;
    take_ill_eret = 1'b0;
    take_irq      = 1'b0;
    do_return     = 1'b0;
    dbl_fault     = 1'b0;
    unique case (state_q)
      ST_NORMAL: begin
        if (bus.NotAnInstr)      take_undef    = 1'b1;
        else if (bus.ERet)       take_ill_eret = 1'b1;
        else if (irq_pend_q)     take_irq      = 1'b1;
      end
      ST_HANDLER: begin
        if (bus.NotAnInstr)      dbl_fault     = 1'b1;
        else if (bus.ERet)       do_return     = 1'b1;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_NORMAL;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (take_undef || take_ill_eret || take_irq) state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (dbl_fault)      state_d = ST_HALTED;
        else if (do_return) state_d = ST_NORMAL;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_NORMAL;
    endcase
  end

  // Redirect outputs and next values of the architectural registers
  always_comb begin
    redirect_c    = 1'b0;
    redirect_pc_c = VECTOR;
    elr_d         = elr_q;
    esr_d         = esr_q;
    // Latch any request while nothing is pending; taking it clears below
    irq_pend_d    = irq_pend_q | bus.ExtIRQ;
    ext_iack_d    = 1'b0;
    halt_d        = halt_q;

    if (take_undef) begin
      redirect_c    = 1'b1;
      redirect_pc_c = VECTOR;
      elr_d         = bus.PC;
      esr_d         = ESR_UNDEF;
    end else if (take_ill_eret) begin
      redirect_c    = 1'b1;
      redirect_pc_c = VECTOR;
      elr_d         = bus.PC;
      esr_d         = ESR_ILLERET;
    end else if (take_irq) begin
      // Current instruction commits, so return to where it would have gone
      redirect_c    = 1'b1;
      redirect_pc_c = VECTOR;
      elr_d         = bus.NextPC;
      esr_d         = ESR_IRQ;
      irq_pend_d    = 1'b0;
      ext_iack_d    = 1'b1;
    end else if (do_return) begin
      redirect_c    = 1'b1;
      redirect_pc_c = elr_q;
    end else if (dbl_fault) begin
      // Spin on the faulting address until reset
      redirect_c    = 1'b1;
      redirect_pc_c = bus.PC;
      esr_d         = ESR_DBLFLT;
      halt_d        = 1'b1;
    end

    if (state_q == ST_HALTED) begin
      redirect_c    = 1'b1;
      redirect_pc_c = bus.PC;
    end
  end

  // Architectural registers, pending flag, acknowledge and halt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elr_q      <= '0;
      esr_q      <= '0;
      irq_pend_q <= 1'b0;
      ext_iack_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      elr_q      <= elr_d;
      esr_q      <= esr_d;
      irq_pend_q <= irq_pend_d;
      ext_iack_q <= ext_iack_d;
      halt_q     <= halt_d;
    end
  end

  // MRS read mux
  always_comb begin
    sysreg_c = '0;
    unique case (bus.SysRegSel)
      2'b00:   sysreg_c = elr_q;
      2'b01:   sysreg_c = PC_W'(esr_q);
      2'b10:   sysreg_c = PC_W'(state_q);
      default: sysreg_c = '0;
    endcase
  end

  assign bus.ExcRedirect = redirect_c;
  assign bus.RedirectPC  = redirect_pc_c;
  assign bus.SysRegOut   = sysreg_c;
  assign bus.ExtIAck     = ext_iack_q;
  assign bus.EProc       = (state_q == ST_HANDLER);
  assign bus.Halt        = halt_q;

endmodule

// File: tb/tb_exc_handler.sv
// Directed self-checking bench for exc_handler.
// Inputs change 1 ns after a rising edge; outputs are checked a few ns later,
// so combinational outputs reflect the new inputs and registered outputs
// reflect the preceding edge.
module tb_exc_handler;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  exc_handler_if ifc ();

  exc_handler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read ELR and ESR through the MRS mux, leaving select at 0
  task automatic chk_regs(input string tag, input logic [63:0] elr, input logic [63:0] esr);
    ifc.SysRegSel = 2'b00; #1;
    chk({tag, "_elr"}, ifc.SysRegOut, elr);
    ifc.SysRegSel = 2'b01; #1;
    chk({tag, "_esr"}, ifc.SysRegOut, esr);
    ifc.SysRegSel = 2'b00;
  endtask

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    ifc.NotAnInstr = 1'b0;
    ifc.ERet       = 1'b0;
    ifc.ExtIRQ     = 1'b0;
    ifc.PC         = 64'h0;
    ifc.NextPC     = 64'h4;
    ifc.SysRegSel  = 2'b00;

    // Reset state
    tick();
    #1;
    chk("rst_eproc", 64'(ifc.EProc), 64'd0);
    chk("rst_halt", 64'(ifc.Halt), 64'd0);
    chk("rst_iack", 64'(ifc.ExtIAck), 64'd0);
    chk("rst_redir", 64'(ifc.ExcRedirect), 64'd0);
    chk_regs("rst", 64'h0, 64'h0);
    reset = 1'b0;

    // Undefined instruction at 0x40
    tick();
    ifc.NotAnInstr = 1'b1; ifc.PC = 64'h40; ifc.NextPC = 64'h44; #1;
    chk("undef_redir", 64'(ifc.ExcRedirect), 64'd1);
    chk("undef_rpc", ifc.RedirectPC, 64'hD8);
    tick();
    ifc.NotAnInstr = 1'b0; ifc.PC = 64'hD8; ifc.NextPC = 64'hDC; #1;
    chk("undef_eproc", 64'(ifc.EProc), 64'd1);
    chk("hdl_idle_redir", 64'(ifc.ExcRedirect), 64'd0);
    chk_regs("undef", 64'h40, 64'h2);

    // ERET back to 0x40
    ifc.ERet = 1'b1; #1;
    chk("ret1_redir", 64'(ifc.ExcRedirect), 64'd1);
    chk("ret1_rpc", ifc.RedirectPC, 64'h40);
    tick();
    ifc.ERet = 1'b0; ifc.PC = 64'h40; ifc.NextPC = 64'h44; #1;
    chk("ret1_eproc", 64'(ifc.EProc), 64'd0);
    chk("ret1_noredir", 64'(ifc.ExcRedirect), 64'd0);

    // One-cycle IRQ pulse; taken the following cycle with ELR=NextPC
    ifc.ExtIRQ = 1'b1; ifc.PC = 64'h44; ifc.NextPC = 64'h48; #1;
    chk("irq_req_noredir", 64'(ifc.ExcRedirect), 64'd0);
    tick();
    ifc.ExtIRQ = 1'b0; #1;
    chk("irq_take_redir", 64'(ifc.ExcRedirect), 64'd1);
    chk("irq_take_rpc", ifc.RedirectPC, 64'hD8);
    chk("irq_take_iack0", 64'(ifc.ExtIAck), 64'd0);
    tick();
    ifc.PC = 64'hD8; ifc.NextPC = 64'hDC; #1;
    chk("irq_iack1", 64'(ifc.ExtIAck), 64'd1);
    chk("irq_eproc", 64'(ifc.EProc), 64'd1);
    ifc.SysRegSel = 2'b00; #1;
    chk("sweep_0", ifc.SysRegOut, 64'h48);
    ifc.SysRegSel = 2'b01; #1;
    chk("sweep_1", ifc.SysRegOut, 64'h1);
    ifc.SysRegSel = 2'b10; #1;
    chk("sweep_2", ifc.SysRegOut, 64'h1);
    ifc.SysRegSel = 2'b11; #1;
    chk("sweep_3", ifc.SysRegOut, 64'h0);
    ifc.SysRegSel = 2'b00;
    tick();
    #1;
    chk("irq_iack_drop", 64'(ifc.ExtIAck), 64'd0);

    // IRQ masked in handler, serviced right after ERET
    ifc.ExtIRQ = 1'b1; #1;
    chk("mask_redir0", 64'(ifc.ExcRedirect), 64'd0);
    tick();
    ifc.ExtIRQ = 1'b0; #1;
    chk("mask_redir1", 64'(ifc.ExcRedirect), 64'd0);
    tick();
    #1;
    chk("mask_redir2", 64'(ifc.ExcRedirect), 64'd0);
    chk("mask_iack", 64'(ifc.ExtIAck), 64'd0);
    ifc.ERet = 1'b1; #1;
    chk("ret2_rpc", ifc.RedirectPC, 64'h48);
    chk("ret2_redir", 64'(ifc.ExcRedirect), 64'd1);
    tick();
    ifc.ERet = 1'b0; ifc.PC = 64'h48; ifc.NextPC = 64'h4C; #1;
    chk("pend_eproc", 64'(ifc.EProc), 64'd0);
    chk("pend_take_redir", 64'(ifc.ExcRedirect), 64'd1);
    chk("pend_take_rpc", ifc.RedirectPC, 64'hD8);
    tick();
    ifc.PC = 64'hD8; ifc.NextPC = 64'hDC; #1;
    chk("pend_iack", 64'(ifc.ExtIAck), 64'd1);
    chk_regs("pend", 64'h4C, 64'h1);
    ifc.ERet = 1'b1;
    tick();
    ifc.ERet = 1'b0; #1;
    chk("ret3_eproc", 64'(ifc.EProc), 64'd0);
    chk("ret3_iack", 64'(ifc.ExtIAck), 64'd0);

    // Undefined instruction and pending IRQ together: fault wins, IRQ retained
    ifc.ExtIRQ = 1'b1; ifc.PC = 64'h4C; ifc.NextPC = 64'h50;
    tick();
    ifc.ExtIRQ = 1'b0; ifc.NotAnInstr = 1'b1; ifc.PC = 64'h10; ifc.NextPC = 64'h14; #1;
    chk("both_rpc", ifc.RedirectPC, 64'hD8);
    tick();
    ifc.NotAnInstr = 1'b0; ifc.PC = 64'hD8; ifc.NextPC = 64'hDC; #1;
    chk("both_iack", 64'(ifc.ExtIAck), 64'd0);
    chk_regs("both", 64'h10, 64'h2);
    ifc.ERet = 1'b1; #1;
    chk("ret4_rpc", ifc.RedirectPC, 64'h10);
    tick();
    ifc.ERet = 1'b0; ifc.PC = 64'h10; ifc.NextPC = 64'h14; #1;
    chk("both_pend_redir", 64'(ifc.ExcRedirect), 64'd1);
    tick();
    ifc.PC = 64'hD8; ifc.NextPC = 64'hDC; #1;
    chk("both_pend_iack", 64'(ifc.ExtIAck), 64'd1);
    chk_regs("both_pend", 64'h14, 64'h1);
    ifc.ERet = 1'b1;
    tick();
    ifc.ERet = 1'b0; #1;

    // ERET outside a handler is itself an exception
    ifc.ERet = 1'b1; ifc.PC = 64'h20; ifc.NextPC = 64'h24; #1;
    chk("illret_rpc", ifc.RedirectPC, 64'hD8);
    chk("illret_redir", 64'(ifc.ExcRedirect), 64'd1);
    tick();
    ifc.ERet = 1'b0; ifc.PC = 64'hD8; ifc.NextPC = 64'hDC; #1;
    chk("illret_eproc", 64'(ifc.EProc), 64'd1);
    chk_regs("illret", 64'h20, 64'h4);

    // Double fault at 0xE0: halt and spin
    ifc.NotAnInstr = 1'b1; ifc.PC = 64'hE0; ifc.NextPC = 64'hE4; #1;
    chk("dbl_redir", 64'(ifc.ExcRedirect), 64'd1);
    chk("dbl_rpc", ifc.RedirectPC, 64'hE0);
    tick();
    ifc.NotAnInstr = 1'b0; ifc.ExtIRQ = 1'b1; #1;
    chk("halt_set", 64'(ifc.Halt), 64'd1);
    chk("halt_eproc", 64'(ifc.EProc), 64'd0);
    chk("halt_rpc", ifc.RedirectPC, 64'hE0);
    chk("halt_redir", 64'(ifc.ExcRedirect), 64'd1);
    chk_regs("halt", 64'h20, 64'h8);
    ifc.SysRegSel = 2'b10; #1;
    chk("halt_state", ifc.SysRegOut, 64'h2);
    ifc.SysRegSel = 2'b00;
    tick();
    ifc.ExtIRQ = 1'b0; #1;
    chk("halt_rpc2", ifc.RedirectPC, 64'hE0);
    chk("halt_sticky", 64'(ifc.Halt), 64'd1);
    chk("halt_iack", 64'(ifc.ExtIAck), 64'd0);

    // Asynchronous reset mid-cycle clears everything without a clock edge
    reset = 1'b1; #1;
    chk("arst_halt", 64'(ifc.Halt), 64'd0);
    chk("arst_eproc", 64'(ifc.EProc), 64'd0);
    chk_regs("arst", 64'h0, 64'h0);
    reset = 1'b0;
    ifc.PC = 64'h0; ifc.NextPC = 64'h4;
    tick();
    #1;
    chk("arst_pend_drop", 64'(ifc.ExcRedirect), 64'd0);
    tick();
    #1;
    chk("arst_pend_drop2", 64'(ifc.ExcRedirect), 64'd0);
    chk("arst_iack", 64'(ifc.ExtIAck), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
